// File: rtl/rvm_mem_ctrl_pkg.sv
// Shared constants for the memory controller: access sizes, FSM states, alignment helpers.
// Latency: none (declarations only).
// Backpressure: n/a.
package rvm_mem_ctrl_pkg;

    localparam logic [1:0] RVM_SZ_B = 2'b00;
    localparam logic [1:0] RVM_SZ_H = 2'b01;
    localparam logic [1:0] RVM_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUS_IF = 2'b01,
        ST_BUS_LS = 2'b10
    } rvm_mem_state_t;

    // The reserved size code 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] rvm_norm_size(input logic [1:0] size);
        return (size == 2'b11) ? RVM_SZ_W : size;
    endfunction

    // True when the access does not sit on its natural boundary.
    function automatic logic rvm_is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == RVM_SZ_H) mis = off[0];
        if (size == RVM_SZ_W) mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/rvm_mem_fmt.sv
// Byte-lane formatter: store lane enables/replication and load byte/half extraction.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module rvm_mem_fmt
    import rvm_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  b_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and half; halves ignore off[0] so misaligned halves align down.
    always_comb begin
        sel_byte = rdata[7:0];
        case (off)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Lane enables, replicated store data and extended load data per access size.
    always_comb begin
        b_en      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (rvm_norm_size(size))
            RVM_SZ_B: begin
                b_en      = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sgn & sel_byte[7]}}, sel_byte};
            end
            RVM_SZ_H: begin
                b_en      = 4'b0011 << {off[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sgn & sel_half[15]}}, sel_half};
            end
            default: begin
                b_en      = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/rvm_mem_ctrl.sv
// Single-port memory controller arbitrating fetch and load/store onto one bus.
// Latency: grant in cycle 0, bus cycle from cycle 1, done pulse one cycle after the unstalled bus cycle.
// Backpressure: mem_stall holds the bus access; requesters hold req until done. Option: RVM_MEM_MISALIGN_TRAP_EN.
module rvm_mem_ctrl
    import rvm_mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_error,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        ls_error,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic        mem_c_en,
    output logic        mem_w_en,
    output logic [3:0]  mem_b_en,
    input  logic        mem_error,
    input  logic        mem_stall
);

    rvm_mem_state_t state, state_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        sgn_q;

    logic        ls_ok;
    logic        if_ok;
    logic        ls_trap;

    logic [3:0]  fmt_b_en;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rdata;

    // A requester in its done cycle is still holding req; mask it so it is not re-issued.
    assign ls_ok = ls_req & ~ls_done;
    assign if_ok = if_req & ~if_done;

`ifdef RVM_MEM_MISALIGN_TRAP_EN
    assign ls_trap = rvm_is_misaligned(rvm_norm_size(ls_size), ls_addr[1:0]);
`else
    assign ls_trap = 1'b0;
`endif

    rvm_mem_fmt u_fmt (
        .size      (size_q),
        .sgn       (sgn_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .b_en      (fmt_b_en),
        .wdata_rep (fmt_wdata),
        .rdata_ext (fmt_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: LS wins in IDLE; bus states leave on the first unstalled cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ls_ok) state_nxt = ls_trap ? ST_IDLE : ST_BUS_LS;
                else if (if_ok) state_nxt = ST_BUS_IF;
            end
            ST_BUS_IF,
            ST_BUS_LS: begin
                if (!mem_stall) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus pins: driven only during a bus state, from the latched request so they stay stable.
    always_comb begin
        mem_c_en  = 1'b0;
        mem_w_en  = 1'b0;
        mem_b_en  = 4'b0000;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state != ST_IDLE) begin
            mem_c_en  = 1'b1;
            mem_w_en  = we_q;
            mem_b_en  = we_q ? fmt_b_en : 4'b1111;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = we_q ? fmt_wdata : 32'd0;
        end
    end

    // Request latch and completion capture; done pulses last exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            size_q   <= RVM_SZ_W;
            we_q     <= 1'b0;
            sgn_q    <= 1'b0;
            if_done  <= 1'b0;
            if_error <= 1'b0;
            if_rdata <= 32'd0;
            ls_done  <= 1'b0;
            ls_error <= 1'b0;
            ls_rdata <= 32'd0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ls_ok) begin
                        addr_q  <= ls_addr;
                        wdata_q <= ls_wdata;
                        size_q  <= rvm_norm_size(ls_size);
                        we_q    <= ls_we;
                        sgn_q   <= ls_signed;
                        if (ls_trap) begin
                            ls_done  <= 1'b1;
                            ls_error <= 1'b1;
                            ls_rdata <= 32'd0;
                        end
                    end else if (if_ok) begin
                        addr_q  <= if_addr;
                        wdata_q <= 32'd0;
                        size_q  <= RVM_SZ_W;
                        we_q    <= 1'b0;
                        sgn_q   <= 1'b0;
                    end
                end
                ST_BUS_IF: begin
                    if (!mem_stall) begin
                        if_done  <= 1'b1;
                        if_error <= mem_error;
                        if_rdata <= mem_error ? 32'd0 : fmt_rdata;
                    end
                end
                ST_BUS_LS: begin
                    if (!mem_stall) begin
                        ls_done  <= 1'b1;
                        ls_error <= mem_error;
                        ls_rdata <= mem_error ? 32'd0 : fmt_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_mem_ctrl.sv
// Self-checking bench for rvm_mem_ctrl: scoreboard of expected completions plus inline timing checks.
// Latency: n/a.
// Backpressure: drives mem_stall directly per scenario.
module tb_rvm_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_error;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_signed;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        ls_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic        mem_w_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;

    typedef struct {
        bit          is_ls;
        bit          chk_rdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    rvm_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_error  (if_error),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_signed (ls_signed),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .ls_done   (ls_done),
        .ls_error  (ls_error),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_c_en  (mem_c_en),
        .mem_w_en  (mem_w_en),
        .mem_b_en  (mem_b_en),
        .mem_error (mem_error),
        .mem_stall (mem_stall)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (if_done || ls_done)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: if_done=%0b ls_done=%0b with no access outstanding", if_done, ls_done);
            end else begin
                exp_t e;
                logic [31:0] got_rd;
                logic        got_err;
                e = exp_q.pop_front();
                got_rd  = e.is_ls ? ls_rdata : if_rdata;
                got_err = e.is_ls ? ls_error : if_error;
                if ((e.is_ls ? ls_done : if_done) !== 1'b1 ||
                    got_err !== e.err ||
                    (e.chk_rdata && got_rd !== e.rdata)) begin
                    miscompares++;
                    $display("FAIL completion(%s): got done=%0b err=%0b rdata=%08h, want done=1 err=%0b rdata=%08h",
                             e.is_ls ? "ls" : "if", e.is_ls ? ls_done : if_done, got_err, got_rd, e.err, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the chosen done pulse is seen; returns cycles taken, or max+1 on timeout.
    task automatic wait_done(input bit is_ls, input int max, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n <= max) begin
            tick();
            n++;
            if (is_ls ? ls_done : if_done) seen = 1'b1;
        end
        if (!seen) n = max + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 2'b10;
        ls_signed = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; mem_error = 0; mem_stall = 0;
        repeat (3) tick();
        vectors++;
        if ({mem_c_en, mem_w_en, mem_b_en} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_bus_ctl: got c_en=%0b w_en=%0b b_en=%b, want all 0", mem_c_en, mem_w_en, mem_b_en);
        end
        vectors++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_bus_data: got addr=%08h wdata=%08h, want 0", mem_addr, mem_wdata);
        end
        vectors++;
        if ({if_done, if_error, ls_done, ls_error} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got if_done=%0b if_err=%0b ls_done=%0b ls_err=%0b, want 0",
                     if_done, if_error, ls_done, ls_error);
        end
        vectors++;
        if ({if_rdata, ls_rdata} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_rdata: got if_rdata=%08h ls_rdata=%08h, want 0", if_rdata, ls_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int n;
        if_req = 1; if_addr = 32'h0000_0100; mem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back('{is_ls: 0, chk_rdata: 1, rdata: 32'hDEAD_BEEF, err: 0});
        tick();
        vectors++;
        if (mem_c_en !== 1'b1 || mem_addr !== 32'h100 || mem_w_en !== 1'b0 || mem_b_en !== 4'hF) begin
            miscompares++;
            $display("FAIL fetch_bus: got c_en=%0b addr=%08h w_en=%0b b_en=%b, want 1/00000100/0/1111",
                     mem_c_en, mem_addr, mem_w_en, mem_b_en);
        end
        wait_done(0, 4, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL fetch_latency: got done %0d cycles after bus cycle, want 1", n);
        end
        if_req = 0;
        tick();
    endtask

    task automatic test_load_extend();
        logic [31:0] addrs [7] = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h201, 32'h202, 32'h700};
        logic [1:0]  sizes [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
        logic        sgns  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exps  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF,
                                   32'h0000_00FF, 32'h0000_80FF, 32'h80FF_FF7F};
        int n;
        mem_rdata = 32'h80FF_FF7F;
        for (int i = 0; i < 7; i++) begin
            ls_req = 1; ls_we = 0; ls_addr = addrs[i]; ls_size = sizes[i]; ls_signed = sgns[i];
            exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: exps[i], err: 0});
            wait_done(1, 5, n);
            vectors++;
            if (n !== 2) begin
                miscompares++;
                $display("FAIL load_latency[%0d]: got %0d cycles, want 2", i, n);
            end
            ls_req = 0;
            tick();
        end
    endtask

    task automatic test_store();
        logic [31:0] addrs [3] = '{32'h42, 32'h41, 32'h40};
        logic [1:0]  sizes [3] = '{2'b01, 2'b00, 2'b10};
        logic [3:0]  bens  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] wds   [3] = '{32'hABCD_ABCD, 32'hCDCD_CDCD, 32'h1234_ABCD};
        int n;
        mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            ls_req = 1; ls_we = 1; ls_addr = addrs[i]; ls_size = sizes[i]; ls_signed = 0;
            ls_wdata = 32'h1234_ABCD;
            exp_q.push_back('{is_ls: 1, chk_rdata: 0, rdata: 32'h0, err: 0});
            tick();
            vectors++;
            if (mem_c_en !== 1'b1 || mem_w_en !== 1'b1 || mem_b_en !== bens[i] ||
                mem_wdata !== wds[i] || mem_addr !== 32'h40) begin
                miscompares++;
                $display("FAIL store_bus[%0d]: got c_en=%0b w_en=%0b b_en=%b wdata=%08h addr=%08h, want 1/1/%b/%08h/00000040",
                         i, mem_c_en, mem_w_en, mem_b_en, mem_wdata, mem_addr, bens[i], wds[i]);
            end
            wait_done(1, 4, n);
            vectors++;
            if (n !== 1) begin
                miscompares++;
                $display("FAIL store_latency[%0d]: got %0d, want 1", i, n);
            end
            ls_req = 0; ls_we = 0;
            tick();
        end
    endtask

    task automatic test_arb_stall();
        // cycle 0: both request; LS wins and is stalled through cycles 1..3
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_signed = 0; ls_addr = 32'h300;
        if_req = 1; if_addr = 32'h400;
        mem_stall = 1; mem_rdata = 32'h55AA_55AA; mem_error = 1;
        exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: 32'h1357_2468, err: 0});
        exp_q.push_back('{is_ls: 0, chk_rdata: 1, rdata: 32'hCAFE_F00D, err: 0});
        tick(); // cycle 1
        vectors++;
        if (mem_c_en !== 1'b1 || mem_addr !== 32'h300) begin
            miscompares++;
            $display("FAIL arb_ls_first: got c_en=%0b addr=%08h, want 1/00000300", mem_c_en, mem_addr);
        end
        tick(); // cycle 2
        tick(); // cycle 3
        vectors++;
        if (mem_c_en !== 1'b1 || mem_addr !== 32'h300 || ls_done !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_stall_hold: got c_en=%0b addr=%08h ls_done=%0b, want 1/00000300/0",
                     mem_c_en, mem_addr, ls_done);
        end
        tick(); // cycle 4: stall released
        mem_stall = 0; mem_rdata = 32'h1357_2468; mem_error = 0;
        tick(); // cycle 5
        vectors++;
        if (ls_done !== 1'b1 || mem_c_en !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_ls_done_c5: got ls_done=%0b c_en=%0b, want 1/0", ls_done, mem_c_en);
        end
        ls_req = 0; mem_rdata = 32'hCAFE_F00D;
        tick(); // cycle 6
        vectors++;
        if (mem_c_en !== 1'b1 || mem_addr !== 32'h400) begin
            miscompares++;
            $display("FAIL arb_if_next: got c_en=%0b addr=%08h, want 1/00000400", mem_c_en, mem_addr);
        end
        tick(); // cycle 7
        vectors++;
        if (if_done !== 1'b1) begin
            miscompares++;
            $display("FAIL arb_if_done_c7: got if_done=%0b, want 1", if_done);
        end
        if_req = 0;
        tick();
    endtask

    task automatic test_error();
        int n;
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h500;
        mem_rdata = 32'hFFFF_0000; mem_error = 1;
        exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: 32'h0, err: 1});
        wait_done(1, 5, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL error_latency: got %0d, want 2", n);
        end
        ls_req = 0; mem_error = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cnt;
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h800; mem_stall = 1;
        tick();
        vectors++;
        if (mem_c_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_busy: got c_en=%0b, want 1", mem_c_en);
        end
        tick();
        reset = 1;
        tick();
        vectors++;
        if (mem_c_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_cen: got c_en=%0b, want 0", mem_c_en);
        end
        reset = 0; ls_req = 0; mem_stall = 0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ls_done || if_done || mem_c_en) cnt++;
        end
        vectors++;
        if (cnt !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: got %0d active cycles after reset, want 0", cnt);
        end
    endtask

    task automatic test_misalign();
        int n;
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_signed = 0; ls_addr = 32'h101;
        mem_rdata = 32'h1122_3344; mem_error = 0;
`ifdef RVM_MEM_MISALIGN_TRAP_EN
        exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: 32'h0, err: 1});
        tick();
        vectors++;
        if (ls_done !== 1'b1 || ls_error !== 1'b1 || mem_c_en !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_trap: got done=%0b err=%0b c_en=%0b, want 1/1/0", ls_done, ls_error, mem_c_en);
        end
        n = 0;
`else
        exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: 32'h1122_3344, err: 0});
        tick();
        vectors++;
        if (mem_c_en !== 1'b1 || mem_addr !== 32'h100 || mem_b_en !== 4'hF) begin
            miscompares++;
            $display("FAIL misalign_aligned: got c_en=%0b addr=%08h b_en=%b, want 1/00000100/1111",
                     mem_c_en, mem_addr, mem_b_en);
        end
        wait_done(1, 4, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL misalign_latency: got %0d, want 1", n);
        end
`endif
        ls_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h600; mem_rdata = 32'h0BAD_CAFE;
        exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: 32'h0BAD_CAFE, err: 0});
        exp_q.push_back('{is_ls: 1, chk_rdata: 1, rdata: 32'h0BAD_CAFE, err: 0});
        wait_done(1, 5, n1);
        wait_done(1, 5, n2);
        ls_req = 0;
        vectors++;
        if (n1 !== 2 || n2 !== 3) begin
            miscompares++;
            $display("FAIL back_to_back: got spacing %0d/%0d, want 2/3", n1, n2);
        end
        tick();
        tick();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_extend();
        test_store();
        test_arb_stall();
        test_error();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
